// File: rtl/spi_sched_pkg.sv
// Shared encodings for the SPI bus scheduler: FSM states, device codes,
// requester indices and the chip-select pattern per device.
package spi_sched_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SELECT = 3'd1;
  localparam logic [2:0] ST_SHIFT  = 3'd2;
  localparam logic [2:0] ST_ACK    = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;
  localparam logic [2:0] ST_DESEL  = 3'd5;

  localparam logic DEV_FLASH = 1'b0;
  localparam logic DEV_SD    = 1'b1;

  localparam logic REQ_LOADER = 1'b0;
  localparam logic REQ_CPU    = 1'b1;

  // cs_n vector is {sd, flash}, active low
  function automatic logic [1:0] cs_n_for(input logic dev);
    return (dev == DEV_SD) ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// Mode-0 byte shifter: MSB first, SCK half-period of DIV sysclk cycles,
// MISO sampled on the rising SCK edge, next MOSI bit presented on the fall.
module spi_byte_shifter #(
  parameter int unsigned DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       lead,
  input  logic [7:0] load_byte,
  input  logic       miso,
  output logic       done_c,
  output logic [7:0] rx_byte,
  output logic       sck,
  output logic       mosi
);

  localparam logic [7:0] HALF_RELOAD = 8'(DIV - 1);

  logic [7:0] half_cnt;
  logic [7:0] sh_reg;
  logic [7:0] rx_reg;
  logic [2:0] bit_cnt;
  logic       active;
  logic       lead_q;
  logic       sck_q;
  logic       half_end;

  assign half_end = active && (half_cnt == 8'd0);
  assign done_c   = half_end && !lead_q && sck_q && (bit_cnt == 3'd7);
  assign rx_byte  = rx_reg;
  assign sck      = sck_q;
  assign mosi     = sh_reg[7];

  // lead_q adds one extra low half-period ahead of the first rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_cnt <= 8'd0;
      sh_reg   <= 8'd0;
      rx_reg   <= 8'd0;
      bit_cnt  <= 3'd0;
      active   <= 1'b0;
      lead_q   <= 1'b0;
      sck_q    <= 1'b0;
    end else if (start) begin
      half_cnt <= HALF_RELOAD;
      sh_reg   <= load_byte;
      bit_cnt  <= 3'd0;
      active   <= 1'b1;
      lead_q   <= lead;
      sck_q    <= 1'b0;
    end else if (active) begin
      if (half_cnt != 8'd0) begin
        half_cnt <= half_cnt - 8'd1;
      end else begin
        half_cnt <= HALF_RELOAD;
        if (lead_q) begin
          lead_q <= 1'b0;
        end else if (!sck_q) begin
          sck_q  <= 1'b1;
          rx_reg <= {rx_reg[6:0], miso};
        end else begin
          sck_q <= 1'b0;
          if (bit_cnt == 3'd7) begin
            active <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            sh_reg  <= {sh_reg[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: rtl/spi_bus_sched.sv
// Two-requester SPI bus scheduler: round-robin arbiter, chip-select
// sequencing for flash/SD, one byte per grant, and pin demultiplexing.
module spi_bus_sched
  import spi_sched_pkg::*;
#(
  parameter int unsigned DIV       = 2,
  parameter int unsigned DESEL_MIN = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       dev0,
  input  logic       dev1,
  input  logic       lock0,
  input  logic       lock1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       flash_cs_n,
  output logic       flash_clk,
  output logic       flash_mosi,
  input  logic       flash_miso,
  output logic       sd_cs_n,
  output logic       sd_clk,
  output logic       sd_mosi,
  input  logic       sd_miso,
  output logic       busy
);

  localparam int unsigned DESEL_CYC    = DESEL_MIN * 2 * DIV;
  localparam logic [15:0] DESEL_RELOAD = 16'(DESEL_CYC - 1);
  localparam logic [15:0] SELECT_RELOAD = 16'(DIV - 1);

  logic [2:0]  state, state_d;
  logic        owner, owner_d;
  logic        last_grant, last_d;
  logic        dev_q, dev_d;
  logic [1:0]  cs_n_q, cs_n_d;
  logic [1:0]  ack_q, ack_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [15:0] cnt, cnt_d;
  logic        busy_q;

  logic        start, lead;
  logic [7:0]  load_byte;
  logic        sck, mosi, miso, done_c;
  logic [7:0]  rx_byte;

  logic        grant_cpu, req_own, lock_own, dev_own;
  logic [7:0]  wdata_own;

  assign grant_cpu = (req0 && req1) ? ~last_grant : req1;
  assign req_own   = (owner == REQ_CPU) ? req1   : req0;
  assign lock_own  = (owner == REQ_CPU) ? lock1  : lock0;
  assign dev_own   = (owner == REQ_CPU) ? dev1   : dev0;
  assign wdata_own = (owner == REQ_CPU) ? wdata1 : wdata0;

  // next-state and registered-output values
  always_comb begin
    state_d   = state;
    owner_d   = owner;
    last_d    = last_grant;
    dev_d     = dev_q;
    cs_n_d    = cs_n_q;
    ack_d     = 2'b00;
    rdata_d   = rdata_q;
    cnt_d     = cnt;
    start     = 1'b0;
    lead      = 1'b0;
    load_byte = wdata_own;
    case (state)
      ST_IDLE: begin
        if (req0 || req1) begin
          owner_d   = grant_cpu;
          last_d    = grant_cpu;
          dev_d     = grant_cpu ? dev1 : dev0;
          load_byte = grant_cpu ? wdata1 : wdata0;
          start     = 1'b1;
          lead      = 1'b1;
          cs_n_d    = cs_n_for(dev_d);
          cnt_d     = SELECT_RELOAD;
          state_d   = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (cnt == 16'd0) state_d = ST_SHIFT;
        else              cnt_d   = cnt - 16'd1;
      end
      ST_SHIFT: begin
        if (done_c) begin
          ack_d[owner] = 1'b1;
          rdata_d      = rx_byte;
          state_d      = ST_ACK;
        end
      end
      ST_ACK: begin
        if (lock_own) begin
          state_d = ST_HOLD;
        end else begin
          cs_n_d  = 2'b11;
          cnt_d   = DESEL_RELOAD;
          state_d = ST_DESEL;
        end
      end
      ST_HOLD: begin
        // a new byte for the same device keeps cs_n low; anything else releases
        if (req_own && (dev_own == dev_q)) begin
          start   = 1'b1;
          state_d = ST_SHIFT;
        end else if (req_own || !lock_own) begin
          cs_n_d  = 2'b11;
          cnt_d   = DESEL_RELOAD;
          state_d = ST_DESEL;
        end
      end
      ST_DESEL: begin
        if (cnt == 16'd0) state_d = ST_IDLE;
        else              cnt_d   = cnt - 16'd1;
      end
      default: begin
        cs_n_d  = 2'b11;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= REQ_LOADER;
      last_grant <= REQ_CPU;
      dev_q      <= DEV_FLASH;
      cs_n_q     <= 2'b11;
      ack_q      <= 2'b00;
      rdata_q    <= 8'h00;
      cnt        <= 16'd0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      last_grant <= last_d;
      dev_q      <= dev_d;
      cs_n_q     <= cs_n_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      cnt        <= cnt_d;
      busy_q     <= ~(cs_n_d[0] & cs_n_d[1]);
    end
  end

  assign miso = (dev_q == DEV_SD) ? sd_miso : flash_miso;

  spi_byte_shifter #(.DIV(DIV)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .lead      (lead),
    .load_byte (load_byte),
    .miso      (miso),
    .done_c    (done_c),
    .rx_byte   (rx_byte),
    .sck       (sck),
    .mosi      (mosi)
  );

  // unselected device pins are forced idle
  assign flash_cs_n = cs_n_q[0];
  assign sd_cs_n    = cs_n_q[1];
  assign flash_clk  = sck  & ~cs_n_q[0];
  assign flash_mosi = mosi & ~cs_n_q[0];
  assign sd_clk     = sck  & ~cs_n_q[1];
  assign sd_mosi    = mosi & ~cs_n_q[1];
  assign ack0       = ack_q[0];
  assign ack1       = ack_q[1];
  assign rdata      = rdata_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_spi_bus_sched.sv
// Directed bench for spi_bus_sched: mode-0 slave models on both devices,
// a DIV=2 instance for the main scenarios and a DIV=1 instance for the edge case.
module tb_spi_bus_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, dev0, dev1, lock0, lock1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, busy;
  logic [7:0] rdata;
  logic       flash_cs_n, flash_clk, flash_mosi, flash_miso;
  logic       sd_cs_n, sd_clk, sd_mosi, sd_miso;

  logic       d1_req0;
  logic       d1_ack0, d1_ack1, d1_busy;
  logic [7:0] d1_rdata;
  logic       d1_flash_cs_n, d1_flash_clk, d1_flash_mosi;
  logic       d1_sd_cs_n, d1_sd_clk, d1_sd_mosi;

  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_bus_sched #(.DIV(2), .DESEL_MIN(2)) u_dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .dev0(dev0), .dev1(dev1),
    .lock0(lock0), .lock1(lock1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .flash_cs_n(flash_cs_n), .flash_clk(flash_clk), .flash_mosi(flash_mosi), .flash_miso(flash_miso),
    .sd_cs_n(sd_cs_n), .sd_clk(sd_clk), .sd_mosi(sd_mosi), .sd_miso(sd_miso),
    .busy(busy)
  );

  spi_bus_sched #(.DIV(1), .DESEL_MIN(1)) u_dut_div1 (
    .clk(clk), .rst(rst), .req0(d1_req0), .req1(1'b0), .dev0(1'b0), .dev1(1'b0),
    .lock0(1'b0), .lock1(1'b0), .wdata0(8'hFF), .wdata1(8'h00),
    .ack0(d1_ack0), .ack1(d1_ack1), .rdata(d1_rdata),
    .flash_cs_n(d1_flash_cs_n), .flash_clk(d1_flash_clk), .flash_mosi(d1_flash_mosi), .flash_miso(1'b0),
    .sd_cs_n(d1_sd_cs_n), .sd_clk(d1_sd_clk), .sd_mosi(d1_sd_mosi), .sd_miso(1'b0),
    .busy(d1_busy)
  );

  // slave models: shift out pattern MSB first, advance on each SCK fall
  logic [7:0] fl_pat = 8'h00, sd_pat = 8'h00;
  logic [2:0] fl_idx = 3'd0, sd_idx = 3'd0;
  logic       fl_clk_p = 1'b0, sd_clk_p = 1'b0, sd_cs_p = 1'b1, d1_clk_p = 1'b0;
  logic [7:0] fl_rx = 8'h00, sd_rx = 8'h00, d1_rx = 8'h00;
  int fl_rises = 0, sd_rises = 0, sd_low_cnt = 0, sd_hi_cnt = 0;
  int ack0_cnt = 0, ack1_cnt = 0, overlap_cnt = 0, idle_bad = 0, busy_bad = 0, d1_bad = 0;
  int last_fl_low = 0, sd_fall_cyc = 0, d1_last_rise = 0, d1_prev_rise = 0;

  assign flash_miso = fl_pat[3'd7 - fl_idx];
  assign sd_miso    = sd_pat[3'd7 - sd_idx];

  always @(negedge clk) begin
    if (flash_cs_n) fl_idx <= 3'd0;
    else if (fl_clk_p && !flash_clk) fl_idx <= fl_idx + 3'd1;
    if (sd_cs_n) sd_idx <= 3'd0;
    else if (sd_clk_p && !sd_clk) sd_idx <= sd_idx + 3'd1;
    if (!fl_clk_p && flash_clk) begin
      fl_rises <= fl_rises + 1;
      fl_rx    <= {fl_rx[6:0], flash_mosi};
    end
    if (!sd_clk_p && sd_clk) begin
      sd_rises <= sd_rises + 1;
      sd_rx    <= {sd_rx[6:0], sd_mosi};
    end
    fl_clk_p <= flash_clk;
    sd_clk_p <= sd_clk;
    sd_cs_p  <= sd_cs_n;
    if (!flash_cs_n) last_fl_low <= int'(cyc);
    if (!sd_cs_n && sd_cs_p) sd_fall_cyc <= int'(cyc);
    if (!sd_cs_n) sd_low_cnt <= sd_low_cnt + 1;
    else          sd_hi_cnt  <= sd_hi_cnt + 1;
    if (ack0) ack0_cnt <= ack0_cnt + 1;
    if (ack1) ack1_cnt <= ack1_cnt + 1;
    if (!flash_cs_n && !sd_cs_n) overlap_cnt <= overlap_cnt + 1;
    if ((flash_cs_n && (flash_clk || flash_mosi)) || (sd_cs_n && (sd_clk || sd_mosi)))
      idle_bad <= idle_bad + 1;
    if (busy !== ~(flash_cs_n & sd_cs_n)) busy_bad <= busy_bad + 1;
    if (!d1_clk_p && d1_flash_clk) begin
      d1_prev_rise <= d1_last_rise;
      d1_last_rise <= int'(cyc);
      d1_rx        <= {d1_rx[6:0], d1_flash_mosi};
    end
    d1_clk_p <= d1_flash_clk;
    if (!d1_sd_cs_n || d1_sd_clk || d1_sd_mosi || d1_ack1 || (d1_busy !== ~d1_flash_cs_n))
      d1_bad <= d1_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // one byte on the DIV=2 instance; lat counts edges from the request edge to ack
  task automatic do_xfer(input logic r, input logic dv, input logic lk, input logic [7:0] wd,
                         input logic [7:0] pat, output int lat, output logic [7:0] rd);
    int  n;
    bit  seen;
    seen = 1'b0;
    lat  = -1;
    rd   = 8'h00;
    if (dv) sd_pat = pat;
    else    fl_pat = pat;
    @(posedge clk); #1;
    if (r) begin req1 = 1'b1; dev1 = dv; lock1 = lk; wdata1 = wd; end
    else   begin req0 = 1'b1; dev0 = dv; lock0 = lk; wdata0 = wd; end
    n = int'(cyc);
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (r ? ack1 : ack0) begin
        seen = 1'b1;
        lat  = int'(cyc) - n;
        rd   = rdata;
      end
    end
    if (r) req1 = 1'b0;
    else   req0 = 1'b0;
    check("ack_seen", 32'(seen), 32'd1);
  endtask

  logic [7:0] lk_bytes [6];
  logic [7:0] lk_pats  [6];
  logic       ord [4];

  initial begin
    int lat, k, n, first_lat, a0, a1, s_low, s_rises, s_hi, s_a1, base, ac;
    logic [7:0] rd, first_rd;
    bit seen;

    lk_bytes = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
    lk_pats  = '{8'h01, 8'hFF, 8'h80, 8'h7E, 8'h00, 8'hA5};
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; dev0 = 1'b0; dev1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    wdata0 = 8'h00; wdata1 = 8'h00; d1_req0 = 1'b0;
    first_lat = -1; first_rd = 8'h00;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n",  32'({flash_cs_n, sd_cs_n}), 32'h3);
    check("rst_pins",  32'({flash_clk, flash_mosi, sd_clk, sd_mosi}), 32'h0);
    check("rst_ack",   32'({ack0, ack1}), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // tie out of reset, both held: 0,1,0,1
    @(posedge clk); #1;
    req0 = 1'b1; req1 = 1'b1; wdata0 = 8'h11; wdata1 = 8'h22; fl_pat = 8'h5A;
    n = int'(cyc); k = 0;
    for (int i = 0; i < 600 && k < 4; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        ord[k] = ack1;
        if (k == 0) begin first_lat = int'(cyc) - n; first_rd = rdata; end
        k++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("tie_count", 32'(k), 32'd4);
    for (int j = 0; j < 4; j++)
      if (j < k) check($sformatf("tie_order%0d", j), 32'(ord[j]), 32'(j % 2));
    check("tie_first_lat", 32'(first_lat), 32'd35);
    check("tie_first_rd", 32'(first_rd), 32'h5A);
    repeat (20) @(posedge clk);

    // single flash transfer from the CPU port
    s_low = sd_low_cnt; s_rises = sd_rises;
    do_xfer(1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, lat, rd);
    check("single_lat", 32'(lat), 32'd35);
    check("single_rdata", 32'(rd), 32'h3C);
    check("single_mosi", 32'(fl_rx), 32'hA5);
    check("single_sd_cs", 32'(sd_low_cnt - s_low), 32'd0);
    check("single_sd_clk", 32'(sd_rises - s_rises), 32'd0);
    @(negedge clk);
    check("single_ack_pulse", 32'(ack1), 32'd0);
    repeat (20) @(posedge clk);

    // locked SD command from the loader with a CPU request arriving mid-sequence
    s_a1 = ack1_cnt; s_hi = 0;
    for (int i = 0; i < 6; i++) begin
      do_xfer(1'b0, 1'b1, (i < 5), lk_bytes[i], lk_pats[i], lat, rd);
      check($sformatf("lock_lat%0d", i), 32'(lat), (i == 0) ? 32'd35 : 32'd33);
      check($sformatf("lock_rd%0d", i), 32'(rd), 32'(lk_pats[i]));
      check($sformatf("lock_mosi%0d", i), 32'(sd_rx), 32'(lk_bytes[i]));
      if (i == 0) begin
        s_hi = sd_hi_cnt;
        req1 = 1'b1; dev1 = 1'b0; lock1 = 1'b0; wdata1 = 8'h3E; fl_pat = 8'hE7;
      end
    end
    a0 = int'(cyc);
    check("lock_cs_held", 32'(sd_hi_cnt - s_hi), 32'd0);
    check("lock_no_early_ack1", 32'(ack1_cnt - s_a1), 32'd0);
    seen = 1'b0; a1 = a0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (ack1) begin seen = 1'b1; a1 = int'(cyc); rd = rdata; end
    end
    req1 = 1'b0;
    check("lock_ack1_seen", 32'(seen), 32'd1);
    check("lock_ack1_after_desel", 32'((a1 - a0) >= 43), 32'd1);
    check("lock_ack1_rd", 32'(rd), 32'hE7);
    check("lock_ack1_mosi", 32'(fl_rx), 32'h3E);
    repeat (20) @(posedge clk);

    // device switch by the same owner
    do_xfer(1'b0, 1'b0, 1'b0, 8'h69, 8'h96, lat, rd);
    check("switch_fl_rd", 32'(rd), 32'h96);
    check("switch_fl_mosi", 32'(fl_rx), 32'h69);
    do_xfer(1'b0, 1'b1, 1'b0, 8'hF0, 8'h0F, lat, rd);
    check("switch_sd_rd", 32'(rd), 32'h0F);
    check("switch_sd_mosi", 32'(sd_rx), 32'hF0);
    check("switch_gap", 32'((sd_fall_cyc - last_fl_low - 1) >= 8), 32'd1);
    repeat (20) @(posedge clk);

    // reset in the middle of the shift
    fl_pat = 8'h96; base = fl_rises; seen = 1'b0;
    @(posedge clk); #1;
    req0 = 1'b1; dev0 = 1'b0; lock0 = 1'b0; wdata0 = 8'h5A;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (fl_rises >= base + 4) seen = 1'b1;
    end
    check("rstmid_reached", 32'(seen), 32'd1);
    ac = ack0_cnt;
    #2 rst = 1'b1;
    #1;
    check("rstmid_cs_n", 32'(flash_cs_n), 32'd1);
    check("rstmid_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    req0 = 1'b0;
    #2 rst = 1'b0;
    repeat (40) @(posedge clk);
    check("rstmid_no_ack", 32'(ack0_cnt - ac), 32'd0);
    do_xfer(1'b0, 1'b0, 1'b0, 8'hC3, 8'h81, lat, rd);
    check("rstmid_after_lat", 32'(lat), 32'd35);
    check("rstmid_after_rd", 32'(rd), 32'h81);
    check("rstmid_after_mosi", 32'(fl_rx), 32'hC3);
    repeat (20) @(posedge clk);

    // DIV=1: wdata 0xFF, miso held low
    @(posedge clk); #1;
    d1_req0 = 1'b1; n = int'(cyc); seen = 1'b0; lat = -1; rd = 8'hFF;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (d1_ack0) begin seen = 1'b1; lat = int'(cyc) - n; rd = d1_rdata; end
    end
    d1_req0 = 1'b0;
    check("div1_ack_seen", 32'(seen), 32'd1);
    check("div1_lat", 32'(lat), 32'd18);
    check("div1_rdata", 32'(rd), 32'h00);
    check("div1_sck_period", 32'(d1_last_rise - d1_prev_rise), 32'd2);
    check("div1_mosi", 32'(d1_rx), 32'hFF);
    repeat (10) @(posedge clk);

    check("cs_overlap", 32'(overlap_cnt), 32'd0);
    check("unselected_idle", 32'(idle_bad), 32'd0);
    check("busy_tracks_cs", 32'(busy_bad), 32'd0);
    check("div1_side_pins", 32'(d1_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_bus_sched.md
# spi_bus_sched

SPI bus scheduler for the shared serial-memory resource: the boot/ROM loader and the CPU-side SPI port both need the SPI flash and the SD card. The block arbitrates between two requesters, sequences chip select for the granted device, and runs one mode-0 byte transfer per grant. It sits between the requesters and the board's flash_* / sd_* pins. It also produces the activity signal that drives testled.

## Interface
- DIV, 2: sysclk cycles per SCK half-period; legal range 1..255.
- DESEL_MIN, 2: minimum chip-select-high time between owners, in SCK periods; must be ≥1.
- clk  in  1  sysclk (28 MHz domain).
- rst  in  1  reset, asynchronous, active-high.
- req0, req1  in  1  level request; requester 0 is the loader, requester 1 is the CPU port. Held until the matching ack.
- dev0, dev1  in  1  target device: 0 = flash, 1 = SD. Sampled at grant.
- lock0, lock1  in  1  keep chip select asserted after this byte (multi-byte command).
- wdata0, wdata1  in  8  byte to send. Must be stable while req is high.
- ack0, ack1  out  1  one-cycle pulse: byte done, rdata valid.
- rdata  out  8  last received byte; holds until the next ack.
- flash_cs_n, flash_clk, flash_mosi  out  1  flash pins.
- flash_miso  in  1  flash data in.
- sd_cs_n, sd_clk, sd_mosi  out  1  SD pins.
- sd_miso  in  1  SD data in.
- busy  out  1  high whenever any cs_n is low; feeds testled.

## Operation
- States:
  - IDLE
  - SELECT
  - SHIFT
  - ACK
  - HOLD
  - DESEL
- IDLE: grants when any req is high.
  - If both requesters ask, the one not granted last wins (round-robin). The last-granted bit resets to 1, so requester 0 wins the first tie.
  - On grant, latch owner, dev and wdata into the shift register, and assert the selected cs_n.
- SELECT: lasts DIV cycles with SCK low and MOSI = bit7.
- SHIFT: 8 SCK periods, MSB first.
  - SCK rises after every DIV cycles low, and MISO of the selected device is sampled on that rise.
  - SCK falls after DIV cycles high, and the next bit is presented on that fall.
  - After the 8th fall, go to ACK.
- ACK: one cycle.
  - ackN = 1 and rdata = the received byte.
  - Next state is HOLD if lockN is high, otherwise DESEL.
- HOLD: cs_n stays low and the other requester is blocked.
  - reqN from the owner reloads wdata and goes directly to SHIFT with MOSI = bit7. SCK stays low for DIV cycles before the first rise.
  - lockN low goes to DESEL.
- DESEL: all cs_n high for DESEL_MIN×2×DIV cycles, then IDLE.
- The non-selected device's clk and mosi stay 0 and its cs_n stays 1 at all times.
- A device switch by the same owner also passes through DESEL.
- A req arriving during DESEL waits.
- A req dropped before its ack is a protocol violation; the transfer completes regardless.

## Timing
- Reset values:
  - cs_n = 1 on both devices
  - clk, mosi = 0
  - ack = 0
  - rdata = 0x00
  - busy = 0
  - state = IDLE
- Reset asserted mid-transfer raises both cs_n asynchronously; no ack is produced.
- Latency from IDLE: req high at edge n → cs_n low at n+1 → ack at n+1+DIV+16·DIV.
  - With DIV=2 this is n+35.
- Latency from HOLD: reqN at edge h → ack at h+1+16·DIV.
- Back-to-back unlocked bytes: ack, then DESEL, then the next grant no earlier than ack+1+2·DESEL_MIN·DIV.
- busy is registered, equals the AND-NOT of both cs_n, and has no combinational path from req.
- Counters:
  - Half-period counter: 8 bits.
  - Bit counter: 3 bits plus a done flag.
  - DESEL counter: 16 bits, sized for DESEL_MIN×2×DIV.

## Structure
- Shared package spi_sched_pkg holds:
  - the state encoding
  - device codes DEV_FLASH = 0 and DEV_SD = 1
  - the requester index constants
- Sub-module spi_byte_shifter holds the shift register, half-period and bit counters, and the SCK/MOSI/MISO sampling.
  - Interface: start, load byte, miso in; done, rx byte, sck, mosi out.
- The top level holds the arbiter, the state machine and the pin demultiplexing.

## Test plan
- Single transfer: req1, dev1=flash, wdata=0xA5, DIV=2, flash_miso pattern 0x3C.
  - Flash MOSI shows 1,0,1,0,0,1,0,1 on rising edges.
  - ack1 fires at n+35 with rdata=0x3C.
  - sd_* pins stay idle.
- Tie: req0 and req1 rise on the same cycle out of reset.
  - Requester 0 is served first, then requester 1.
  - With both held continuously, grants alternate 0,1,0,1.
- Locked command: requester 0 sends SD bytes 0x40,0x00,0x00,0x00,0x00,0x95 with lock0 high for bytes 0–4.
  - sd_cs_n stays low across all 6 bytes.
  - req1 raised during the sequence is delayed until after DESEL.
- Device switch: owner sends flash then SD unlocked.
  - Both cs_n are high for ≥2·DESEL_MIN·DIV cycles between the two transfers.
  - Both cs_n are never low together.
- Reset mid-SHIFT (after bit 3):
  - cs_n goes high in the same cycle as reset.
  - No ack is produced.
  - After release, a new request completes normally with correct data.
- DIV=1 edge case with wdata=0xFF and miso=0x00.
  - ack at n+18.
  - rdata=0x00.
  - SCK period is 2 cycles.
